flight_cmd_sequencer: RTL and testbench
=======================================

# flight_cmd_sequencer

Command sequencer between the UART command wrapper and the flight-control datapath inside `QuadCopter`. It accepts decoded 8-bit command / 16-bit data pairs and loads the desired pitch/roll/yaw/thrust registers. It sequences inertial calibration (ESC settle, then `strt_cal`, then wait for done), and handles emergency-land and motors-off. It returns an acknowledge byte to the host for every command and runs a loss-of-link watchdog that zeroes the flight setpoints.

## Interface
- `FAST_SIM`, 1, shortens counters for simulation. SETTLE_W = FAST_SIM ? 9 : 22; WD_W = FAST_SIM ? 10 : 26.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_rdy`  in  1  command/data valid from UART wrapper; held until cleared
- `cmd`  in  8  command opcode
- `data`  in  16  command payload
- `clr_cmd_rdy`  out  1  one-cycle clear of `cmd_rdy` (combinational)
- `send_resp`  out  1  one-cycle request to transmit `resp` (combinational)
- `resp`  out  8  response byte: 8'hA5 ack, 8'hEE nack
- `cal_done`  in  1  inertial calibration complete pulse
- `strt_cal`  out  1  one-cycle calibration start (registered)
- `inertial_cal`  out  1  high from calibration accept until `cal_done`
- `d_ptch`, `d_roll`, `d_yaw`  out  16  signed desired angles
- `thrst`  out  9  unsigned desired thrust
- `motors_off`  out  1  forces ESC outputs to minimum

## Operation
- Opcodes: 02 SET_PTCH, 03 SET_ROLL, 04 SET_YAW, 05 SET_THRST, 06 SET_CAL, 07 SET_EMGL, 08 SET_MOFF. Any other value: nack 8'hEE, no register change.
- States: IDLE, CAL_SETTLE, CAL_WAIT.
- IDLE, `cmd_rdy`=1: assert `clr_cmd_rdy` in the same cycle and decode.
  - 02/03/04: load `data` into the matching angle register.
  - 05: `thrst` <= `data[8:0]` (upper bits ignored).
  - 07: all three angles and `thrst` <= 0.
  - 08: `motors_off` <= 1, `thrst` <= 0.
  - For each of the above, `send_resp`=1 with `resp`=8'hA5 in the same cycle.
- 06 in IDLE: clear `motors_off`, set `inertial_cal`, clear settle counter, go CAL_SETTLE. No response yet.
- CAL_SETTLE: count 2^SETTLE_W cycles, then pulse `strt_cal` for one cycle and go CAL_WAIT.
- CAL_WAIT: on `cal_done`, clear `inertial_cal`, pulse `send_resp` with 8'hA5, go IDLE.
- Outside IDLE, `cmd_rdy` is not serviced. The command stays pending and is accepted on the first IDLE cycle.
- Watchdog (WD_W-bit counter):
  - Cleared on every accepted command and whenever state is not IDLE; increments otherwise.
  - On reaching all-ones it saturates and forces angles and `thrst` to 0, the same effect as 07 but with no response byte.
  - The zeroing repeats each cycle while saturated. Cleared by the next accepted command.
- `resp` holds its last value between pulses.

## Timing
- Reset values: all setpoints 0, `motors_off`=1, `inertial_cal`=0, `strt_cal`=0, `resp`=8'h00, state IDLE, both counters 0.
- Register-load commands: setpoint visible the cycle after `clr_cmd_rdy` (1-cycle latency).
- The UART wrapper drops `cmd_rdy` at that edge, so a command is never double-accepted.
- SET_CAL latency: `strt_cal` at accept+1+2^SETTLE_W cycles; ack in the `cal_done` cycle.
- `cal_done` in IDLE or CAL_SETTLE is ignored.
- `cal_done` and a new `cmd_rdy` together in CAL_WAIT: finish calibration first; the command is accepted the next cycle.
- Watchdog expiry in the same cycle as `cmd_rdy`: the command wins and the counter clears.
- `rst_n` low mid-calibration: immediate return to reset values; no `strt_cal`, no response.

## Structure
- Package `flight_pkg`: opcode localparams (SET_PTCH..SET_MOFF), `ACK`=8'hA5, `NACK`=8'hEE, state enum typedef.
- Sub-module `wd_timer`: parameterised saturating counter with clear input and expiry output. It is instanced once for the watchdog and reused for the settle counter (width SETTLE_W).
- Remainder is one FSM plus setpoint registers.

## Test plan
- Reset: `motors_off`=1, all setpoints 0.
- SET_PTCH 16'h0100, SET_ROLL 16'hFF80, SET_YAW 16'h0080, SET_THRST 16'h00FF:
  - each gives a one-cycle `clr_cmd_rdy` and `send_resp` with 8'hA5;
  - next cycle `d_ptch`=256, `d_roll`=-128, `d_yaw`=128, `thrst`=255.
- SET_CAL, FAST_SIM=1:
  - `motors_off` drops and `inertial_cal` rises;
  - `strt_cal` fires exactly 513 cycles after accept;
  - a SET_PTCH sent mid-calibration stays pending;
  - `cal_done` produces 8'hA5 with `inertial_cal`=0; the pending SET_PTCH is accepted next cycle.
- SET_EMGL after flight setpoints: all setpoints 0, ack 8'hA5. SET_MOFF: `motors_off`=1, `thrst`=0, ack.
- Watchdog: after setpoints load, idle 1023 cycles; angles and `thrst` go 0 with no `send_resp`. A new SET_THRST 16'h0080 restores `thrst`=128.
- Opcode 8'h3C gives nack 8'hEE with no setpoint change. `rst_n` pulse during CAL_SETTLE gives reset values and no `strt_cal`.

Source files
------------

// File: rtl/flight_pkg.sv
// flight_pkg: opcodes, response bytes and sequencer states shared by the flight command path
package flight_pkg;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] SET_CAL   = 8'h06;
  localparam logic [7:0] SET_EMGL  = 8'h07;
  localparam logic [7:0] SET_MOFF  = 8'h08;
  localparam logic [7:0] ACK       = 8'hA5;
  localparam logic [7:0] NACK      = 8'hEE;
  typedef enum logic [1:0] {IDLE, CAL_SETTLE, CAL_WAIT} state_t;
endpackage

// File: rtl/wd_timer.sv
// wd_timer: saturating up-counter with synchronous clear; expired while all-ones
module wd_timer #(
  parameter int W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);
  logic [W-1:0] cnt_q;
  assign expired = &cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= clr ? '0 : expired ? cnt_q : cnt_q + 1'b1;
endmodule

// File: rtl/flight_cmd_sequencer.sv
// flight_cmd_sequencer: decodes host commands into setpoints, sequences calibration, loss-of-link watchdog
module flight_cmd_sequencer
  import flight_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  output logic               clr_cmd_rdy,
  output logic               send_resp,
  output logic [7:0]         resp,
  input  logic               cal_done,
  output logic               strt_cal,
  output logic               inertial_cal,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off
);
  localparam int SETTLE_W = FAST_SIM ? 9 : 22;
  localparam int WD_W     = FAST_SIM ? 10 : 26;
  state_t state_q, state_d;
  logic signed [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [8:0] thrst_q, thrst_d;
  logic [7:0] resp_q, resp_d;
  logic moff_q, moff_d, ical_q, ical_d, strt_q, strt_d;
  logic wd_clr, wd_exp, settle_exp;
  wd_timer #(.W(WD_W)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr(wd_clr), .expired(wd_exp)
  );
  wd_timer #(.W(SETTLE_W)) u_settle (
    .clk(clk), .rst_n(rst_n), .clr(state_q != CAL_SETTLE), .expired(settle_exp)
  );
  always_comb begin
    state_d = state_q;
    ptch_d = ptch_q;
    roll_d = roll_q;
    yaw_d = yaw_q;
    thrst_d = thrst_q;
    moff_d = moff_q;
    ical_d = ical_q;
    strt_d = 1'b0;
    resp_d = resp_q;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    wd_clr = state_q != IDLE;
    case (state_q)
      IDLE:
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          wd_clr = 1'b1;
          send_resp = 1'b1;
          resp_d = ACK;
          case (cmd)
            SET_PTCH:  ptch_d = data;
            SET_ROLL:  roll_d = data;
            SET_YAW:   yaw_d = data;
            SET_THRST: thrst_d = data[8:0];
            SET_CAL: begin
              // calibration is acknowledged only once cal_done arrives
              send_resp = 1'b0;
              resp_d = resp_q;
              moff_d = 1'b0;
              ical_d = 1'b1;
              state_d = CAL_SETTLE;
            end
            SET_EMGL: {ptch_d, roll_d, yaw_d, thrst_d} = '0;
            SET_MOFF: begin
              moff_d = 1'b1;
              thrst_d = '0;
            end
            default: resp_d = NACK;
          endcase
        end else if (wd_exp) {ptch_d, roll_d, yaw_d, thrst_d} = '0;
      CAL_SETTLE:
        if (settle_exp) begin
          strt_d = 1'b1;
          state_d = CAL_WAIT;
        end
      CAL_WAIT:
        if (cal_done) begin
          ical_d = 1'b0;
          send_resp = 1'b1;
          resp_d = ACK;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptch_q <= '0;
      roll_q <= '0;
      yaw_q <= '0;
      thrst_q <= '0;
      moff_q <= 1'b1;
      ical_q <= 1'b0;
      strt_q <= 1'b0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      ptch_q <= ptch_d;
      roll_q <= roll_d;
      yaw_q <= yaw_d;
      thrst_q <= thrst_d;
      moff_q <= moff_d;
      ical_q <= ical_d;
      strt_q <= strt_d;
      resp_q <= resp_d;
    end
  assign resp = resp_d;
  assign strt_cal = strt_q;
  assign inertial_cal = ical_q;
  assign d_ptch = ptch_q;
  assign d_roll = roll_q;
  assign d_yaw = yaw_q;
  assign thrst = thrst_q;
  assign motors_off = moff_q;
endmodule

// File: tb/tb_flight_cmd_sequencer.sv
// tb_flight_cmd_sequencer: timestamp-based reference model plus directed and random command traffic
module tb_flight_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_rdy = 1'b0, cal_done = 1'b0;
  logic [7:0] cmd = '0;
  logic [15:0] data = '0;
  logic clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
  logic [7:0] resp;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0] thrst;
  int checks = 0, errors = 0;
  int tcyc = 0, acc_cyc = 0, strt_cyc = 0, nsend = 0, nstrt = 0;
  flight_cmd_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp), .cal_done(cal_done),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal), .d_ptch(d_ptch), .d_roll(d_roll),
    .d_yaw(d_yaw), .thrst(thrst), .motors_off(motors_off)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask
  // Model: setpoints as plain variables; calibration phase and watchdog age derived from timestamps
  logic [15:0] m_ptch = '0, m_roll = '0, m_yaw = '0;
  logic [8:0] m_thr = '0;
  logic [7:0] m_resp = '0;
  bit m_moff = 1'b1, m_ical = 1'b0, cal_active = 1'b0;
  int cal_acc = 0, clear_ref = 0;
  always @(negedge clk) begin
    logic e_clr, e_send, e_strt;
    e_clr = 1'b0; e_send = 1'b0; e_strt = 1'b0;
    if (!rst_n) begin
      {m_ptch, m_roll, m_yaw, m_thr, m_resp} = '0;
      m_moff = 1'b1; m_ical = 1'b0; cal_active = 1'b0;
      clear_ref = tcyc + 1;
    end
    chk("d_ptch", d_ptch, m_ptch);
    chk("d_roll", d_roll, m_roll);
    chk("d_yaw", d_yaw, m_yaw);
    chk("thrst", 16'(thrst), 16'(m_thr));
    chk("motors_off", 16'(motors_off), 16'(m_moff));
    chk("inertial_cal", 16'(inertial_cal), 16'(m_ical));
    if (rst_n) begin
      e_strt = cal_active && (tcyc - cal_acc == 513);
      if (!cal_active) begin
        if (cmd_rdy) begin
          e_clr = 1'b1; e_send = 1'b1; m_resp = 8'hA5;
          clear_ref = tcyc + 1;
          case (cmd)
            8'h02: m_ptch = data;
            8'h03: m_roll = data;
            8'h04: m_yaw = data;
            8'h05: m_thr = data[8:0];
            8'h06: begin e_send = 1'b0; m_resp = resp_q_hold(); cal_active = 1'b1; cal_acc = tcyc; m_moff = 1'b0; m_ical = 1'b1; end
            8'h07: {m_ptch, m_roll, m_yaw, m_thr} = '0;
            8'h08: begin m_moff = 1'b1; m_thr = '0; end
            default: m_resp = 8'hEE;
          endcase
        end else if (tcyc - clear_ref >= 1023) {m_ptch, m_roll, m_yaw, m_thr} = '0;
      end else begin
        clear_ref = tcyc + 1;
        if (tcyc - cal_acc >= 513 && cal_done) begin
          cal_active = 1'b0; m_ical = 1'b0; e_send = 1'b1; m_resp = 8'hA5;
        end
      end
    end
    chk("clr_cmd_rdy", 16'(clr_cmd_rdy), 16'(e_clr));
    chk("send_resp", 16'(send_resp), 16'(e_send));
    chk("resp", 16'(resp), 16'(m_resp));
    chk("strt_cal", 16'(strt_cal), 16'(e_strt));
    last_resp = m_resp;
  end
  logic [7:0] last_resp = '0;
  function automatic logic [7:0] resp_q_hold();
    return last_resp;
  endfunction
  always @(negedge clk) begin
    if (clr_cmd_rdy && cmd == 8'h06) acc_cyc = tcyc;
    if (strt_cal) begin strt_cyc = tcyc; nstrt++; end
    if (send_resp) nsend++;
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic await_clr();
    int n = 0;
    @(negedge clk);
    while (!clr_cmd_rdy && n < 3000) begin n++; @(negedge clk); end
    chk("handshake", 16'(clr_cmd_rdy), 16'd1);
    @(posedge clk); #1 cmd_rdy = 1'b0;
  endtask
  task automatic send(input logic [7:0] c, input logic [15:0] d);
    @(posedge clk); #1 cmd = c; data = d; cmd_rdy = 1'b1;
    await_clr();
  endtask
  task automatic pulse_done();
    @(posedge clk); #1 cal_done = 1'b1;
    @(posedge clk); #1 cal_done = 1'b0;
  endtask
  task automatic do_cal();
    int k;
    send(8'h06, 16'($urandom));
    k = $urandom_range(5, 400);
    idle(k); pulse_done(); idle(515 - k);
    @(posedge clk); #1 cal_done = 1'b1; cmd = 8'(2 + $urandom_range(0, 3)); data = 16'($urandom); cmd_rdy = 1'b1;
    @(posedge clk); #1 cal_done = 1'b0;
    await_clr();
  endtask
  initial begin
    int s0, n0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_moff", 16'(motors_off), 16'd1);
    chk("rst_thrst", 16'(thrst), 16'd0);
    send(8'h02, 16'h0100); send(8'h03, 16'hFF80); send(8'h04, 16'h0080); send(8'h05, 16'h00FF);
    @(negedge clk);
    chk("pin_ptch", d_ptch, 16'd256);
    chk("pin_roll", d_roll, 16'hFF80);
    chk("pin_yaw", d_yaw, 16'd128);
    chk("pin_thrst", 16'(thrst), 16'd255);
    send(8'h06, 16'h0000);
    @(negedge clk);
    chk("cal_moff", 16'(motors_off), 16'd0);
    chk("cal_ical", 16'(inertial_cal), 16'd1);
    idle(100);
    @(posedge clk); #1 cmd = 8'h02; data = 16'h1234; cmd_rdy = 1'b1;
    idle(450);
    @(posedge clk); #1 cal_done = 1'b1;
    @(negedge clk);
    chk("cal_ack", 16'(send_resp), 16'd1);
    chk("cal_ack_byte", 16'(resp), 16'h00A5);
    chk("cal_pending", 16'(clr_cmd_rdy), 16'd0);
    @(posedge clk); #1 cal_done = 1'b0;
    @(negedge clk);
    chk("pending_acc", 16'(clr_cmd_rdy), 16'd1);
    @(posedge clk); #1 cmd_rdy = 1'b0;
    @(negedge clk);
    chk("pending_ptch", d_ptch, 16'h1234);
    chk("cal_ical_off", 16'(inertial_cal), 16'd0);
    chk("strt_latency", 16'(strt_cyc - acc_cyc), 16'd513);
    send(8'h07, 16'h0000);
    @(negedge clk);
    chk("emgl", 16'(d_ptch | d_roll | d_yaw | 16'(thrst)), 16'd0);
    send(8'h05, 16'h0055); send(8'h08, 16'h0000);
    @(negedge clk);
    chk("moff", 16'(motors_off), 16'd1);
    chk("moff_thrst", 16'(thrst), 16'd0);
    chk("moff_ack", 16'(resp), 16'h00A5);
    send(8'h05, 16'h01FF); send(8'h02, 16'h0005);
    n0 = nsend;
    idle(1100);
    @(negedge clk);
    chk("wd_thrst", 16'(thrst), 16'd0);
    chk("wd_ptch", d_ptch, 16'd0);
    chk("wd_silent", 16'(nsend - n0), 16'd0);
    send(8'h05, 16'h0080);
    @(negedge clk);
    chk("wd_restore", 16'(thrst), 16'd128);
    send(8'h3C, 16'hFFFF);
    @(negedge clk);
    chk("nack", 16'(resp), 16'h00EE);
    chk("nack_thrst", 16'(thrst), 16'd128);
    send(8'h06, 16'h0000);
    idle(100);
    @(posedge clk); #1 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    s0 = nstrt; n0 = nsend;
    idle(700);
    @(negedge clk);
    chk("rst_nostrt", 16'(nstrt - s0), 16'd0);
    chk("rst_noresp", 16'(nsend - n0), 16'd0);
    chk("rst_ical", 16'(inertial_cal), 16'd0);
    chk("rst_moff2", 16'(motors_off), 16'd1);
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) send((r < 10) ? 8'(2 + r % 4) : 8'(7 + r % 2), 16'($urandom));
      else if (r == 12) send(8'($urandom_range(9, 255)), 16'($urandom));
      else if (r == 13) do_cal();
      else if (r == 14) pulse_done();
      else idle($urandom_range(1, 6));
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
